alu_regfile_core: RTL and testbench
===================================

Name: alu_regfile_core

Overview:
- Execution core of the 16-bit TSC pipelined datapath: a 4-entry x 16-bit register file plus a combinational 16-bit ALU.
- Register file is read in ID and written from WB.
- ALU operates in EX on operands already selected and forwarded by the datapath.
- No pipeline registers inside this block; the datapath owns all staging.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 4, number of architectural registers (2-bit address).

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset_N  input  1  reset; active-high, synchronous (name kept per codebase convention, polarity is high).
- reg_write  input  1  register write enable, sampled at rising Clk.
- read_addr1  input  2  read port 1 address (rs).
- read_addr2  input  2  read port 2 address (rt).
- write_addr  input  2  write port address.
- write_data  input  16  write port data.
- read_data1  output  16  read port 1 data, combinational.
- read_data2  output  16  read port 2 data, combinational.
- alu_a  input  16  ALU operand A.
- alu_b  input  16  ALU operand B.
- alu_op  input  3  ALU operation select.
- alu_result  output  16  ALU result, combinational.
- alu_overflow  output  1  signed overflow flag, combinational.

Behaviour:
- Register file: four 16-bit registers, R0..R3.
  - No hardwired-zero register; R0 is writable.
- Reset: on rising Clk with Reset_N=1, all four registers become 0x0000.
  - Reset overrides a simultaneous write.
  - Reset mid-operation discards any pending write that cycle.
- Write: on rising Clk with Reset_N=0 and reg_write=1, R[write_addr] <= write_data.
  - Takes effect in one cycle.
  - reg_write=0 leaves all registers unchanged.
- Read: read_dataN = R[read_addrN], combinational, zero-cycle latency.
  - Both ports may address the same register.
- Write-through bypass:
  - Applies when reg_write=1, Reset_N=0 and read_addrN == write_addr.
  - read_dataN then returns write_data in the same cycle, before the clock edge. This covers the WB-to-ID hazard.
  - The bypass applies independently to each read port.
- ALU, purely combinational, 16-bit, results truncated mod 2^16:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND: A&B
  - 3 ORR: A|B
  - 4 NOT: ~A
  - 5 TCP: two's complement, ~A+1
  - 6 SHL: A<<1, zero fill
  - 7 SHR: A>>1, arithmetic, sign bit replicated
- alu_b is ignored for ops 4-7.
- Overflow, signed, two's complement:
  - ADD: set when A[15]==B[15] and result[15]!=A[15].
  - SUB: set when A[15]!=B[15] and result[15]!=A[15].
  - All other ops: 0, including TCP of 0x8000.
- Datapath usage this block must support:
  - Op 0 with B=0 passes A through, for PC+1 link and LHI ({imm,8'h00}+0).
  - The R-type funct field [2:0] maps directly onto alu_op.
- ALU output has no reset dependence; it is valid whenever its inputs are.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_ORR=3, OP_NOT=4, OP_TCP=5, OP_SHL=6, OP_SHR=7.
  - WIDTH and register-address width.
- One natural sub-module, alu16: the combinational ALU.
  - It is instantiated by alu_regfile_core.
  - The register file, with its bypass, stays in the top.

Test Plan:
- Reset: write 0x1234 to R2, then assert Reset_N=1 for one edge -> all read ports return 0x0000; a write asserted during the reset edge is lost.
- Write/read: write R0=0x00AA, R3=0xFFFF on successive edges; read_addr1=0, read_addr2=3 -> 0x00AA and 0xFFFF; reg_write=0 with write_addr=0 and data 0x5555 -> R0 stays 0x00AA.
- Bypass: R1=0x0001; drive reg_write=1, write_addr=1, write_data=0x7777, read_addr1=read_addr2=1 -> both reads show 0x7777 before the edge and keep it after.
- ALU arithmetic:
  - ADD 0x7FFF+0x0001 -> 0x8000, ovf=1.
  - SUB 0x8000-0x0001 -> 0x7FFF, ovf=1.
  - ADD 0xFFFF+0x0001 -> 0x0000, ovf=0.
  - TCP 0x0005 -> 0xFFFB, ovf=0.
- ALU logic/shift with A=0x8F0F, B=0x00FF:
  - AND -> 0x000F
  - ORR -> 0x8FFF
  - NOT -> 0x70F0
  - SHL -> 0x1E1E
  - SHR -> 0xC787
  - ovf=0 for all five.
- LHI/link: A=0x5A00, B=0, op ADD -> 0x5A00; A=0x0010, B=0 -> 0x0010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the TSC execution core: widths and ALU op encodings.
package alu_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREGS = 4;
   localparam int unsigned AW    = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_ORR = 3'd3;
   localparam logic [2:0] OP_NOT = 3'd4;
   localparam logic [2:0] OP_TCP = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU with signed-overflow flag for ADD/SUB only.
module alu16
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] res_d;
   logic             ovf_d;

   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      unique case (op_i)
         OP_ADD: begin
            res_d = a_i + b_i;
            ovf_d = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = a_i - b_i;
            ovf_d = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND: res_d = a_i & b_i;
         OP_ORR: res_d = a_i | b_i;
         OP_NOT: res_d = ~a_i;
         // TCP never flags overflow, even for the most negative value
         OP_TCP: res_d = ~a_i + WIDTH'(1);
         OP_SHL: res_d = {a_i[WIDTH-2:0], 1'b0};
         OP_SHR: res_d = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
         default: res_d = '0;
      endcase
   end

   assign result_o = res_d;
   assign ovf_o    = ovf_d;

endmodule

// File: rtl/alu_regfile_core.sv
// TSC execution core: 4x16 register file with write-through bypass plus the ALU.
module alu_regfile_core
   import alu_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_N,
   input  logic             reg_write,
   input  logic [AW-1:0]    read_addr1,
   input  logic [AW-1:0]    read_addr2,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] read_data1,
   output logic [WIDTH-1:0] read_data2,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_overflow
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic             wr_en;

   // Reset_N is active-high; it also suppresses the write and the bypass
   assign wr_en = reg_write && !Reset_N;

   always_comb begin
      for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
      if (wr_en) regs_d[write_addr] = write_data;
   end

   always_ff @(posedge Clk) begin
      if (Reset_N) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign read_data1 = (wr_en && (read_addr1 == write_addr)) ? write_data : regs_q[read_addr1];
   assign read_data2 = (wr_en && (read_addr2 == write_addr)) ? write_data : regs_q[read_addr2];

   alu16 u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_result),
      .ovf_o    (alu_overflow)
   );

endmodule

// File: tb/tb_alu_regfile_core.sv
// Directed self-checking bench for alu_regfile_core.
module tb_alu_regfile_core;

   logic        Clk = 1'b0;
   logic        Reset_N;
   logic        reg_write;
   logic [1:0]  read_addr1, read_addr2, write_addr;
   logic [15:0] write_data;
   logic [15:0] read_data1, read_data2;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        ovf;
   } alu_vec_t;

   always #5 Clk = ~Clk;

   alu_regfile_core dut (
      .Clk          (Clk),
      .Reset_N      (Reset_N),
      .reg_write    (reg_write),
      .read_addr1   (read_addr1),
      .read_addr2   (read_addr2),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_data1   (read_data1),
      .read_data2   (read_data2),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_overflow (alu_overflow)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_N = 1'b1; reg_write = 1'b0; write_addr = 2'd0; write_data = 16'h0;
      read_addr1 = 2'd0; read_addr2 = 2'd0;
      tick();
      Reset_N = 1'b0; reg_write = 1'b1; write_addr = 2'd2; write_data = 16'h1234;
      tick();
      reg_write = 1'b0; read_addr1 = 2'd2;
      #1;
      checks++;
      if (read_data1 !== 16'h1234) begin
         $display("FAIL reset_prewrite got %h exp %h", read_data1, 16'h1234); errors++;
      end
      // reset edge with a simultaneous write to R3: write and bypass both suppressed
      Reset_N = 1'b1; reg_write = 1'b1; write_addr = 2'd3; write_data = 16'hBEEF;
      read_addr1 = 2'd3;
      #1;
      checks++;
      if (read_data1 !== 16'h0000) begin
         $display("FAIL reset_no_bypass got %h exp %h", read_data1, 16'h0000); errors++;
      end
      tick();
      Reset_N = 1'b0; reg_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         read_addr1 = 2'(i); read_addr2 = 2'(3 - i);
         #1;
         checks++;
         if (read_data1 !== 16'h0000) begin
            $display("FAIL reset_r%0d_p1 got %h exp %h", i, read_data1, 16'h0000); errors++;
         end
         checks++;
         if (read_data2 !== 16'h0000) begin
            $display("FAIL reset_r%0d_p2 got %h exp %h", 3 - i, read_data2, 16'h0000); errors++;
         end
      end
   endtask

   task automatic test_write_read();
      reg_write = 1'b1; write_addr = 2'd0; write_data = 16'h00AA;
      tick();
      write_addr = 2'd3; write_data = 16'hFFFF;
      tick();
      reg_write = 1'b0; read_addr1 = 2'd0; read_addr2 = 2'd3;
      #1;
      checks++;
      if (read_data1 !== 16'h00AA) begin
         $display("FAIL wr_r0 got %h exp %h", read_data1, 16'h00AA); errors++;
      end
      checks++;
      if (read_data2 !== 16'hFFFF) begin
         $display("FAIL wr_r3 got %h exp %h", read_data2, 16'hFFFF); errors++;
      end
      write_addr = 2'd0; write_data = 16'h5555;
      tick();
      #1;
      checks++;
      if (read_data1 !== 16'h00AA) begin
         $display("FAIL wr_disabled_r0 got %h exp %h", read_data1, 16'h00AA); errors++;
      end
      read_addr1 = 2'd1; read_addr2 = 2'd2;
      #1;
      checks++;
      if (read_data1 !== 16'h0000) begin
         $display("FAIL wr_r1_untouched got %h exp %h", read_data1, 16'h0000); errors++;
      end
      checks++;
      if (read_data2 !== 16'h0000) begin
         $display("FAIL wr_r2_untouched got %h exp %h", read_data2, 16'h0000); errors++;
      end
   endtask

   task automatic test_bypass();
      reg_write = 1'b1; write_addr = 2'd1; write_data = 16'h0001;
      tick();
      reg_write = 1'b0; read_addr1 = 2'd1; read_addr2 = 2'd1;
      #1;
      checks++;
      if (read_data1 !== 16'h0001) begin
         $display("FAIL byp_setup got %h exp %h", read_data1, 16'h0001); errors++;
      end
      reg_write = 1'b1; write_addr = 2'd1; write_data = 16'h7777;
      #1;
      checks++;
      if (read_data1 !== 16'h7777) begin
         $display("FAIL byp_pre_p1 got %h exp %h", read_data1, 16'h7777); errors++;
      end
      checks++;
      if (read_data2 !== 16'h7777) begin
         $display("FAIL byp_pre_p2 got %h exp %h", read_data2, 16'h7777); errors++;
      end
      read_addr2 = 2'd0;
      #1;
      checks++;
      if (read_data2 !== 16'h00AA) begin
         $display("FAIL byp_indep_p2 got %h exp %h", read_data2, 16'h00AA); errors++;
      end
      checks++;
      if (read_data1 !== 16'h7777) begin
         $display("FAIL byp_indep_p1 got %h exp %h", read_data1, 16'h7777); errors++;
      end
      read_addr2 = 2'd1;
      tick();
      reg_write = 1'b0; write_data = 16'h0000;
      #1;
      checks++;
      if (read_data1 !== 16'h7777) begin
         $display("FAIL byp_post_p1 got %h exp %h", read_data1, 16'h7777); errors++;
      end
      checks++;
      if (read_data2 !== 16'h7777) begin
         $display("FAIL byp_post_p2 got %h exp %h", read_data2, 16'h7777); errors++;
      end
   endtask

   task automatic run_alu_table(input string tag, input alu_vec_t v[$]);
      foreach (v[i]) begin
         alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
         #1;
         checks++;
         if (alu_result !== v[i].res) begin
            $display("FAIL %s_%0d_res op=%0d a=%h b=%h got %h exp %h",
                     tag, i, v[i].op, v[i].a, v[i].b, alu_result, v[i].res);
            errors++;
         end
         checks++;
         if (alu_overflow !== v[i].ovf) begin
            $display("FAIL %s_%0d_ovf op=%0d a=%h b=%h got %b exp %b",
                     tag, i, v[i].op, v[i].a, v[i].b, alu_overflow, v[i].ovf);
            errors++;
         end
      end
   endtask

   task automatic test_alu_arith();
      alu_vec_t v[$];
      v.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1});
      v.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1});
      v.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
      v.push_back('{3'd5, 16'h0005, 16'h1234, 16'hFFFB, 1'b0});
      v.push_back('{3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0});
      v.push_back('{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1});
      v.push_back('{3'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1});
      v.push_back('{3'd1, 16'h0005, 16'h0003, 16'h0002, 1'b0});
      v.push_back('{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0});
      run_alu_table("arith", v);
   endtask

   task automatic test_alu_logic();
      alu_vec_t v[$];
      v.push_back('{3'd2, 16'h8F0F, 16'h00FF, 16'h000F, 1'b0});
      v.push_back('{3'd3, 16'h8F0F, 16'h00FF, 16'h8FFF, 1'b0});
      v.push_back('{3'd4, 16'h8F0F, 16'h00FF, 16'h70F0, 1'b0});
      v.push_back('{3'd6, 16'h8F0F, 16'h00FF, 16'h1E1E, 1'b0});
      v.push_back('{3'd7, 16'h8F0F, 16'h00FF, 16'hC787, 1'b0});
      v.push_back('{3'd7, 16'h4002, 16'hFFFF, 16'h2001, 1'b0});
      v.push_back('{3'd4, 16'h8F0F, 16'hFFFF, 16'h70F0, 1'b0});
      run_alu_table("logic", v);
   endtask

   task automatic test_lhi_link();
      alu_vec_t v[$];
      v.push_back('{3'd0, 16'h5A00, 16'h0000, 16'h5A00, 1'b0});
      v.push_back('{3'd0, 16'h0010, 16'h0000, 16'h0010, 1'b0});
      run_alu_table("pass", v);
   endtask

   initial begin
      Reset_N = 1'b1; reg_write = 1'b0;
      read_addr1 = '0; read_addr2 = '0; write_addr = '0; write_data = '0;
      alu_a = '0; alu_b = '0; alu_op = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_alu_arith();
      test_alu_logic();
      test_lhi_link();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
